nlfsr_period_checker: RTL and testbench
=======================================

Name: nlfsr_period_checker

Overview:
Parametrised successor to the team's fixed-seed full-period NLFSR tester. It loads a programmable seed into a SIZE-bit shift register that takes its feedback bit from external feedback logic. It steps the register and measures the exact cycle length back to the seed. It reports found (period equals TARGET), failure (shorter or different period), or timeout (the seed is never revisited), along with the measured period. It sits between the feedback-function generator and the search controller, which issues start pulses and collects results.

Parameters:
SIZE, 16, register width in bits (min 2)
CNT_W, SIZE+1, step counter / period width; must hold 2**SIZE
TARGET, 2**SIZE-1, period that counts as success (full period)

Ports:
clk  in  1  clock; all logic on rising edge
res  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a measurement; honoured only in IDLE or DONE
seed  in  SIZE  start state, sampled on the accepted start
ena  in  1  step enable; when low during RUN, state and counter hold
feedback  in  1  next input bit from external feedback logic, combinational function of state
state  out  SIZE  current shift-register contents
busy  out  1  high in RUN
done  out  1  high in DONE; results valid
found  out  1  measured period == TARGET
failure  out  1  seed revisited with period != TARGET
timeout  out  1  2**SIZE steps without revisiting seed
period  out  CNT_W  measured period; 0 on timeout

Behaviour:
- Reset (res=0, asynchronous):
  - FSM=IDLE
  - state = all ones
  - seed register = all ones
  - counter = 0
  - busy, done, found, failure, timeout = 0
  - period = 0
  - Reset mid-RUN aborts the measurement immediately; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - seed register <= seed
  - state <= seed
  - counter <= 0
  - found, failure, timeout, done <= 0
  - period <= 0
  - next state RUN
  - busy is high from the following cycle.
- RUN with ena=0: everything holds.
- RUN with ena=1, each cycle:
  - next = {state[SIZE-2:0], feedback}
  - state <= next
  - cnt1 = counter + 1, computed in CNT_W bits without overflow
  - counter <= cnt1
- End conditions, evaluated in the same RUN step cycle, first match wins:
  - next == seed register: period <= cnt1; found <= (cnt1 == TARGET); failure <= (cnt1 != TARGET); go DONE.
  - Otherwise, cnt1 == 2**SIZE: timeout <= 1; period <= 0; go DONE. The seed lies on a tail, not a cycle.
- Completion timing: done rises the cycle after the final step. state then shows the final next value.
- A period of 1 (fixed point) is detected after a single step.
- DONE: results and state hold until the next start. Exactly one of found, failure, timeout is high.
- start during RUN: ignored; the measurement continues.
- start in the same cycle as the final step: ignored (FSM is still RUN).
- A seed of all zeros is legal; there is no special casing.
- The feedback input is sampled only when RUN and ena are both high.

Test Plan:
- SIZE=4, TARGET=15, feedback=state[3]^state[2], seed=4'b1111, ena=1, start pulse -> busy for 15 cycles, then done=1, found=1, period=15, failure=0, timeout=0, state=4'b1111.
- SIZE=4, feedback=state[3] (rotation), seed=4'b1010 -> after 2 steps done=1, failure=1, period=2, found=0. Repeat with seed=4'b1111 -> failure=1, period=1.
- SIZE=4, feedback=0, seed=4'b1111 -> state reaches 0000 and sticks; after 16 steps done=1, timeout=1, period=0, found=0, failure=0.
- Maximal-length case with ena toggled 1/0 every cycle -> same found=1, period=15; done after 30 RUN cycles; state and counter unchanged on ena=0 cycles.
- Start pulses during RUN are ignored, with result unchanged (period=15). A start in DONE restarts, clearing done/found on the next cycle and setting busy=1.
- Drive res low mid-RUN (after 7 steps) -> same cycle asynchronously: busy=0, done=0, state=4'b1111, period=0. After release, a new start measures cleanly to period=15.

Source files
------------

// File: rtl/nlfsr_period_checker.sv
// rtl/nlfsr_period_checker.sv - measures the cycle length of an externally fed NLFSR from a seed
//
// Purpose:
//   Loads a seed into a SIZE-bit left-shifting register whose input bit comes
//   from external feedback logic, steps it and counts steps until the seed
//   comes back. Reports found (period == TARGET), failure (other period) or
//   timeout (2**SIZE steps without revisiting the seed, period reported as 0).
//
// Ports:
//   i_clk       clock, rising edge
//   i_res       asynchronous active-low reset
//   i_start     single-cycle start pulse, honoured in IDLE or DONE
//   i_seed      start state, sampled on an accepted start
//   i_ena       step enable while running
//   i_feedback  next shift-in bit, combinational function of o_state
//   o_state     current shift-register contents
//   o_busy      measurement in progress
//   o_done      results valid
//   o_found     measured period == TARGET
//   o_failure   seed revisited with period != TARGET
//   o_timeout   seed never revisited within 2**SIZE steps
//   o_period    measured period (0 on timeout)

module nlfsr_period_checker #(
  parameter int SIZE   = 16,
  parameter int CNT_W  = SIZE + 1,
  parameter int TARGET = (2 ** SIZE) - 1
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_start,
  input  logic [SIZE-1:0]  i_seed,
  input  logic             i_ena,
  input  logic             i_feedback,
  output logic [SIZE-1:0]  o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic             o_failure,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_period
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  // Step count at which the seed is declared to lie on a tail
  localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(1) << SIZE;
  localparam logic [CNT_W-1:0] C_TARGET = CNT_W'(TARGET);

  fsm_t             r_fsm;
  logic [SIZE-1:0]  r_state;
  logic [SIZE-1:0]  r_seed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_found;
  logic             r_failure;
  logic             r_timeout;
  logic [CNT_W-1:0] r_period;

  logic [SIZE-1:0]  w_next;
  logic [CNT_W-1:0] w_cnt1;

  assign w_next = {r_state[SIZE-2:0], i_feedback};
  assign w_cnt1 = r_cnt + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_res) begin
    if (!i_res) begin
      r_fsm     <= S_IDLE;
      r_state   <= '1;
      r_seed    <= '1;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_found   <= 1'b0;
      r_failure <= 1'b0;
      r_timeout <= 1'b0;
      r_period  <= '0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_seed    <= i_seed;
            r_state   <= i_seed;
            r_cnt     <= '0;
            r_found   <= 1'b0;
            r_failure <= 1'b0;
            r_timeout <= 1'b0;
            r_done    <= 1'b0;
            r_period  <= '0;
            r_busy    <= 1'b1;
            r_fsm     <= S_RUN;
          end
        end
        S_RUN: begin
          // start is ignored here; only ena moves the measurement forward
          if (i_ena) begin
            r_state <= w_next;
            r_cnt   <= w_cnt1;
            // Seed match takes priority over the step limit
            if (w_next == r_seed) begin
              r_period  <= w_cnt1;
              r_found   <= (w_cnt1 == C_TARGET);
              r_failure <= (w_cnt1 != C_TARGET);
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_fsm     <= S_DONE;
            end else if (w_cnt1 == C_FULL) begin
              r_timeout <= 1'b1;
              r_period  <= '0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_fsm     <= S_DONE;
            end
          end
        end
        default: begin
          r_fsm  <= S_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_found   = r_found;
  assign o_failure = r_failure;
  assign o_timeout = r_timeout;
  assign o_period  = r_period;

endmodule

// File: tb/tb_nlfsr_period_checker.sv
// tb/tb_nlfsr_period_checker.sv - self-checking bench for nlfsr_period_checker
module tb_nlfsr_period_checker;

  localparam int SIZE  = 4;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             res;
  logic             start;
  logic [SIZE-1:0]  seed;
  logic             ena;
  logic             feedback;
  logic [SIZE-1:0]  state;
  logic             busy, done, found, failure, timeout;
  logic [CNT_W-1:0] period;

  int mode;  // 0: maximal-length LFSR, 1: rotation, 2: constant zero

  nlfsr_period_checker #(.SIZE(SIZE), .CNT_W(CNT_W), .TARGET(15)) dut (
    .i_clk(clk), .i_res(res), .i_start(start), .i_seed(seed), .i_ena(ena),
    .i_feedback(feedback), .o_state(state), .o_busy(busy), .o_done(done),
    .o_found(found), .o_failure(failure), .o_timeout(timeout), .o_period(period)
  );

  always #5 clk = ~clk;

  always_comb begin
    feedback = 1'b0;
    case (mode)
      0: feedback = state[3] ^ state[2];
      1: feedback = state[3];
      default: feedback = 1'b0;
    endcase
  end

  typedef struct {
    logic             found;
    logic             failure;
    logic             timeout;
    logic [CNT_W-1:0] period;
    logic [SIZE-1:0]  fstate;
    int               cycles;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fb_model(input int m, input logic [3:0] s);
    case (m)
      0: return s[3] ^ s[2];
      1: return s[3];
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input int m, input logic [3:0] sd, input bit tog);
    exp_t e;
    logic [3:0] s;
    int steps;
    e.found = 0; e.failure = 0; e.timeout = 0; e.period = 0;
    s = sd;
    steps = 16;
    for (int k = 1; k <= 16; k++) begin
      s = {s[2:0], fb_model(m, s)};
      if (s == sd) begin
        steps = k;
        e.period = CNT_W'(k);
        e.found = (k == 15);
        e.failure = (k != 15);
        break;
      end
    end
    if (steps == 16 && s != sd) e.timeout = 1;
    e.fstate = s;
    e.cycles = tog ? 2 * steps : steps;
    return e;
  endfunction

  task automatic measure(input int m, input logic [3:0] sd, input bit tog, input bit start_mid,
                         input string tag);
    exp_t e;
    int cycles;
    logic [3:0] ps;
    logic pe;
    sb.push_back(model(m, sd, tog));
    @(negedge clk);
    mode = m; seed = sd; ena = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (tog) ena = ~ena;
      start = (start_mid && (cycles == 5 || cycles == 6));
      ps = state;
      pe = ena;
      @(negedge clk);
      if (!pe) check({tag, "_hold"}, 32'(state), 32'(ps));
    end
    start = 1'b0;
    ena = 1'b1;
    e = sb.pop_front();
    check({tag, "_bound"}, 32'(cycles < 200), 32'd1);
    check({tag, "_cycles"}, 32'(cycles), 32'(e.cycles));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_found"}, 32'(found), 32'(e.found));
    check({tag, "_failure"}, 32'(failure), 32'(e.failure));
    check({tag, "_timeout"}, 32'(timeout), 32'(e.timeout));
    check({tag, "_period"}, 32'(period), 32'(e.period));
    check({tag, "_state"}, 32'(state), 32'(e.fstate));
  endtask

  initial begin
    mode = 0; start = 0; seed = 0; ena = 1; res = 0;
    #12;
    check("rst_state", 32'(state), 32'hF);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_flags", 32'({found, failure, timeout}), 0);
    check("rst_period", 32'(period), 0);
    @(negedge clk);
    res = 1;

    // Constant expectations alongside the model
    measure(0, 4'b1111, 0, 0, "max");
    check("max_const_period", 32'(period), 15);
    measure(1, 4'b1010, 0, 0, "rot2");
    check("rot2_const_period", 32'(period), 2);
    measure(1, 4'b1111, 0, 0, "rot1");
    check("rot1_const_period", 32'(period), 1);
    measure(2, 4'b1111, 0, 0, "zero");
    check("zero_const_timeout", 32'(timeout), 1);
    measure(0, 4'b1111, 1, 0, "toggle");
    check("toggle_const_cycles_period", 32'(period), 15);
    measure(0, 4'b0110, 0, 1, "start_mid");
    check("start_mid_const_period", 32'(period), 15);
    measure(0, 4'b0000, 0, 0, "seed0");

    // Restart from DONE: flags clear and busy rises on the next cycle
    @(negedge clk);
    mode = 0; seed = 4'b1111; start = 1;
    @(negedge clk);
    start = 0;
    check("restart_done", 32'(done), 0);
    check("restart_found", 32'(found), 0);
    check("restart_busy", 32'(busy), 1);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    check("restart_period", 32'(period), 15);

    // Reset mid-run after 7 steps, observed before the next clock edge
    @(negedge clk);
    seed = 4'b1001; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #2 res = 0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_state", 32'(state), 32'hF);
    check("arst_period", 32'(period), 0);
    @(negedge clk);
    res = 1;
    measure(0, 4'b1111, 0, 0, "after_rst");

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
